// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg
//   Shared types and helpers for the 4-source round-robin bus arbiter.
//   Contents:
//     state_t        arbiter state {IDLE, GRANT, TURNAROUND}
//     NUM_REQ        number of bus sources (4)
//     owner_t        2-bit source index
//     owner_to_nsel  owner index -> active-low 4-bit select vector
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANT      = 2'd1,
      TURNAROUND = 2'd2
   } state_t;

   localparam int unsigned NUM_REQ = 4;

   typedef logic [1:0] owner_t;

   function automatic logic [NUM_REQ-1:0] owner_to_nsel(input owner_t idx);
      logic [NUM_REQ-1:0] nsel;
      nsel      = '1;
      nsel[idx] = 1'b0;
      return nsel;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
//   Combinational 4-way round-robin priority picker. Returns the first set
//   request bit searching PTR, PTR+1, ... (mod 4).
//   Ports:
//     REQ   [3:0] in   request vector (bit0 = A ... bit3 = D)
//     PTR   [1:0] in   index with highest priority
//     VALID       out  at least one request set
//     IDX   [1:0] out  winning index (equals PTR when VALID is low)
module rr_pick4
   import bus_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] REQ,
   input  owner_t             PTR,
   output logic               VALID,
   output owner_t             IDX
);

   owner_t cand;

   always_comb begin
      VALID = 1'b0;
      IDX   = PTR;
      cand  = PTR;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         // owner_t arithmetic wraps mod 4, giving the rotating search order
         cand = PTR + owner_t'(i);
         if (!VALID && REQ[cand]) begin
            VALID = 1'b1;
            IDX   = cand;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter4_decoded.sv
// bus_arbiter4_decoded
//   Round-robin arbiter driving the active-low enables of a 4:1 decoded
//   tri-state bus mux. At most one select is low at any time, and a
//   break-before-make gap of DEAD_CYCLES all-high cycles separates owners.
//   All outputs come straight from flops; reset is asynchronous so the bus
//   is released immediately on RST.
//   Optional feature (macro BUS_ARB_TIMEOUT_EN): an owner that has held the
//   bus MAX_HOLD cycles is forced off when another source is requesting.
//   Parameters:
//     DEAD_CYCLES  all-high cycles between grants (>= 1)
//     MAX_HOLD     hold limit, used only with BUS_ARB_TIMEOUT_EN
//     HOLD_W       hold counter width, 2**HOLD_W > MAX_HOLD
//   Ports:
//     CLK              in   clock, rising edge
//     RST              in   asynchronous active-high reset
//     REQ      [3:0]   in   level requests, bit0 = A ... bit3 = D
//     N_SEL_A..N_SEL_D out  active-low bus enables (registered)
//     GNT      [3:0]   out  one-hot active-high grant (~N_SEL_D..N_SEL_A)
//     OWNER    [1:0]   out  current or most recent owner
//     BUSY             out  high in GRANT and TURNAROUND
module bus_arbiter4_decoded
   import bus_arb_pkg::*;
#(
   parameter int unsigned DEAD_CYCLES = 1,
   parameter int unsigned MAX_HOLD    = 16,
   parameter int unsigned HOLD_W      = 5
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_REQ-1:0] REQ,
   output logic               N_SEL_A,
   output logic               N_SEL_B,
   output logic               N_SEL_C,
   output logic               N_SEL_D,
   output logic [NUM_REQ-1:0] GNT,
   output logic [1:0]         OWNER,
   output logic               BUSY
);

   localparam int unsigned    DEAD_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_CYCLES - 1);

   if (DEAD_CYCLES < 1 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_param_check
      $error("bus_arbiter4_decoded: DEAD_CYCLES must be >= 1 and 2**HOLD_W > MAX_HOLD");
   end

   state_t             state_q, state_n;
   logic [NUM_REQ-1:0] nsel_q, nsel_n;
   owner_t             owner_q, owner_n;
   owner_t             ptr_q, ptr_n;
   logic [DEAD_W-1:0]  dead_q, dead_n;
   logic               busy_q, busy_n;

   logic               pick_valid;
   owner_t             pick_idx;
   logic               timeout_hit;
   logic               release_bus;

`ifdef BUS_ARB_TIMEOUT_EN
   logic [HOLD_W-1:0]  hold_q, hold_n;
   logic               others_req;

   // In GRANT nsel_q is high everywhere except the owner, so it masks the
   // owner out of REQ.
   assign others_req  = |(REQ & nsel_q);
   assign timeout_hit = (hold_q == HOLD_W'(MAX_HOLD - 1)) && others_req;
`else
   assign timeout_hit = 1'b0;
`endif

   rr_pick4 u_pick (
      .REQ   (REQ),
      .PTR   (ptr_q),
      .VALID (pick_valid),
      .IDX   (pick_idx)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         nsel_q  <= '1;
         owner_q <= '0;
         ptr_q   <= '0;
         dead_q  <= '0;
         busy_q  <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
         hold_q  <= '0;
`endif
      end else begin
         state_q <= state_n;
         nsel_q  <= nsel_n;
         owner_q <= owner_n;
         ptr_q   <= ptr_n;
         dead_q  <= dead_n;
         busy_q  <= busy_n;
`ifdef BUS_ARB_TIMEOUT_EN
         hold_q  <= hold_n;
`endif
      end
   end

   always_comb begin
      state_n     = state_q;
      nsel_n      = nsel_q;
      owner_n     = owner_q;
      ptr_n       = ptr_q;
      dead_n      = dead_q;
      release_bus = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_n      = hold_q;
`endif

      case (state_q)
         GRANT: begin
            release_bus = !REQ[owner_q] || timeout_hit;
            if (release_bus) begin
               nsel_n  = '1;
               dead_n  = DEAD_INIT;
               state_n = TURNAROUND;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if (hold_q != HOLD_W'(MAX_HOLD)) begin
               hold_n = hold_q + 1'b1;
            end
`endif
         end

         // IDLE and the last TURNAROUND cycle share one arbitration path.
         default: begin
            if (state_q == TURNAROUND && dead_q != '0) begin
               dead_n = dead_q - 1'b1;
            end else if (pick_valid) begin
               state_n = GRANT;
               nsel_n  = owner_to_nsel(pick_idx);
               owner_n = pick_idx;
               ptr_n   = pick_idx + 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
               hold_n  = '0;
`endif
            end else begin
               state_n = IDLE;
            end
         end
      endcase

      busy_n = (state_n != IDLE);
   end

   assign N_SEL_A = nsel_q[0];
   assign N_SEL_B = nsel_q[1];
   assign N_SEL_C = nsel_q[2];
   assign N_SEL_D = nsel_q[3];
   assign GNT     = ~nsel_q;
   assign OWNER   = owner_q;
   assign BUSY    = busy_q;

endmodule

// File: tb/tb_bus_arbiter4_decoded.sv
module tb_bus_arbiter4_decoded;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int TB_MAX_HOLD = 4;
   localparam int TB_HOLD_W   = 3;
   localparam bit TB_TO       = 1'b1;
`else
   localparam int TB_MAX_HOLD = 16;
   localparam int TB_HOLD_W   = 5;
   localparam bit TB_TO       = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] REQ = 4'b0000;
   logic       chk_en = 1'b0;

   wire [1:0][3:0] nsel_v;
   wire [1:0][3:0] gnt_v;
   wire [1:0][1:0] own_v;
   wire [1:0]      busy_v;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   // Instance 0: DEAD_CYCLES = 1, instance 1: DEAD_CYCLES = 3; same REQ.
   bus_arbiter4_decoded #(.DEAD_CYCLES(1), .MAX_HOLD(TB_MAX_HOLD), .HOLD_W(TB_HOLD_W)) dut0 (
      .CLK(CLK), .RST(RST), .REQ(REQ),
      .N_SEL_A(nsel_v[0][0]), .N_SEL_B(nsel_v[0][1]), .N_SEL_C(nsel_v[0][2]), .N_SEL_D(nsel_v[0][3]),
      .GNT(gnt_v[0]), .OWNER(own_v[0]), .BUSY(busy_v[0]));

   bus_arbiter4_decoded #(.DEAD_CYCLES(3), .MAX_HOLD(TB_MAX_HOLD), .HOLD_W(TB_HOLD_W)) dut1 (
      .CLK(CLK), .RST(RST), .REQ(REQ),
      .N_SEL_A(nsel_v[1][0]), .N_SEL_B(nsel_v[1][1]), .N_SEL_C(nsel_v[1][2]), .N_SEL_D(nsel_v[1][3]),
      .GNT(gnt_v[1]), .OWNER(own_v[1]), .BUSY(busy_v[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who owns the bus, how many all-high cycles remain,
   // the next round-robin start, and how long the owner has held the bus.
   int m_own  [2] = '{-1, -1};
   int m_last [2] = '{0, 0};
   int m_rr   [2] = '{0, 0};
   int m_gap  [2] = '{0, 0};
   int m_held [2] = '{0, 0};

   always @(posedge CLK or posedge RST) begin
      for (int k = 0; k < 2; k++) begin
         if (RST) begin
            m_own[k] = -1; m_last[k] = 0; m_rr[k] = 0; m_gap[k] = 0; m_held[k] = 0;
         end else if (m_own[k] >= 0) begin
            automatic int o = m_own[k];
            automatic logic [3:0] mask = 4'b0001 << o;
            automatic bit others = ((REQ & ~mask) != 4'b0000);
            if (!REQ[o] || (TB_TO && m_held[k] >= TB_MAX_HOLD - 1 && others)) begin
               m_own[k] = -1;
               m_gap[k] = (k == 0) ? 1 : 3;
            end else begin
               m_held[k]++;
            end
         end else if (m_gap[k] > 1) begin
            m_gap[k]--;
         end else begin
            m_gap[k] = 0;
            for (int j = 0; j < 4; j++) begin
               automatic int c = (m_rr[k] + j) % 4;
               if (m_own[k] < 0 && REQ[c]) begin
                  m_own[k]  = c;
                  m_last[k] = c;
                  m_rr[k]   = (c + 1) % 4;
                  m_held[k] = 0;
               end
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            automatic logic [3:0] en = (m_own[k] >= 0) ? (4'b0001 << m_own[k]) : 4'b0000;
            check($sformatf("dut%0d nsel", k), {28'd0, nsel_v[k]}, {28'd0, ~en});
            check($sformatf("dut%0d gnt", k), {28'd0, gnt_v[k]}, {28'd0, en});
            check($sformatf("dut%0d owner", k), {30'd0, own_v[k]}, m_last[k]);
            check($sformatf("dut%0d busy", k), {31'd0, busy_v[k]},
                  {31'd0, (m_own[k] >= 0 || m_gap[k] > 0)});
            check($sformatf("dut%0d one_low", k), {31'd0, ($countones(~nsel_v[k]) <= 1)}, 32'd1);
         end
      end
   end

   task automatic do_reset();
      @(posedge CLK);
      #3;
      RST = 1'b1;
      REQ = 4'b0000;
      @(posedge CLK);
      #2;
      RST = 1'b0;
   endtask

   initial begin
      int order[$];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      logic [3:0] g, prev_g;
      int held_cnt, zero_run, hi0, hi1, a_cnt, cnt;

      repeat (2) @(posedge CLK);
      #2;
      RST    = 1'b0;
      chk_en = 1'b1;

      // Single request from idle, one-cycle latency.
      repeat (2) @(posedge CLK);
      #2;
      REQ = 4'b0100;
      #1;
      check("lat_before_edge", {28'd0, gnt_v[0]}, 32'h0);
      @(posedge CLK);
      #1;
      check("c_nsel", {28'd0, nsel_v[0]}, 32'hB);
      check("c_gnt", {28'd0, gnt_v[0]}, 32'h4);
      check("c_owner", {30'd0, own_v[0]}, 32'd2);
      check("c_busy", {31'd0, busy_v[0]}, 32'd1);
      REQ = 4'b0000;
      repeat (3) @(posedge CLK);

      // All four requesting, each owner drops after 2 granted cycles.
      do_reset();
      REQ = 4'b1111;
      prev_g = 4'b0000; held_cnt = 0; zero_run = 0;
      for (int c = 0; c < 40 && order.size() < 5; c++) begin
         @(posedge CLK);
         #1;
         g = gnt_v[0];
         if (g != 4'b0000) begin
            if (g == prev_g) held_cnt++;
            else begin
               if (order.size() > 0) check("rr_gap", zero_run, 1);
               order.push_back($clog2(g));
               held_cnt = 1;
               zero_run = 0;
            end
            if (held_cnt == 2) REQ = 4'b1111 & ~g;
         end else begin
            zero_run++;
            REQ = 4'b1111;
         end
         prev_g = g;
      end
      check("rr_count", order.size(), 5);
      for (int i = 0; i < 5 && i < order.size(); i++)
         check($sformatf("rr_order[%0d]", i), order[i], exp_order[i]);

      // Dead time: A drops while B requests.
      do_reset();
      REQ = 4'b0001;
      @(posedge CLK);
      #1;
      check("dead_a_gnt", {28'd0, gnt_v[1]}, 32'h1);
      REQ = 4'b0010;
      hi0 = 0; hi1 = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge CLK);
         #1;
         if (gnt_v[0] == 4'b0000) hi0++;
         if (gnt_v[1] == 4'b0000) hi1++;
         else break;
      end
      check("dead1_cycles", hi0, 1);
      check("dead3_cycles", hi1, 3);
      check("dead3_gnt", {28'd0, gnt_v[1]}, 32'h2);
      check("dead1_gnt", {28'd0, gnt_v[0]}, 32'h2);

      // Asynchronous reset while D is granted.
      do_reset();
      REQ = 4'b1000;
      @(posedge CLK);
      #1;
      check("d_gnt", {28'd0, gnt_v[0]}, 32'h8);
      @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      check("rst_nsel0", {28'd0, nsel_v[0]}, 32'hF);
      check("rst_nsel1", {28'd0, nsel_v[1]}, 32'hF);
      check("rst_busy", {31'd0, busy_v[0]}, 32'd0);
      check("rst_owner", {30'd0, own_v[0]}, 32'd0);
      @(posedge CLK);
      #2;
      RST = 1'b0;
      REQ = 4'b1001;
      @(posedge CLK);
      #1;
      check("post_rst_gnt", {28'd0, gnt_v[0]}, 32'h1);

`ifdef BUS_ARB_TIMEOUT_EN
      // Forced release after MAX_HOLD cycles when B is waiting.
      do_reset();
      REQ = 4'b0001;
      @(posedge CLK);
      #1;
      REQ = 4'b0011;
      a_cnt = (gnt_v[0] == 4'b0001) ? 1 : 0;
      hi0 = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge CLK);
         #1;
         if (gnt_v[0] == 4'b0001) a_cnt++;
         else if (gnt_v[0] == 4'b0000) hi0++;
         else break;
      end
      check("to_a_cycles", a_cnt, 4);
      check("to_dead", hi0, 1);
      check("to_b_gnt", {28'd0, gnt_v[0]}, 32'h2);
`endif

      // Sole requester keeps the bus for 50 cycles.
      do_reset();
      REQ = 4'b0001;
      cnt = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge CLK);
         #1;
         if (gnt_v[0] == 4'b0001 && gnt_v[1] == 4'b0001) cnt++;
      end
      check("solo_hold", cnt, 50);

      REQ = 4'b0000;
      repeat (5) @(posedge CLK);
      #1;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
